// File: rtl/isa_pkg.sv
// isa_pkg: shared ISA decode types used by front-end and EX blocks.
//   decode_ctrl_t - packed decoded control word carried with each
//                   control-flow instruction down the pipeline.
package isa_pkg;

  typedef struct packed {
    logic       is_branch;  // conditional branch
    logic       is_jal;     // direct jump
    logic       is_jalr;    // indirect jump
    logic [2:0] funct3;     // branch condition encoding
  } decode_ctrl_t;

endpackage

// File: rtl/branch_resolve_queue_if.sv
// branch_resolve_queue_if: bundles the fetch allocation channel, the EX
// resolution channel, the redirect output and the BHT update stream of
// branch_resolve_queue.
//   master modport - pipeline side: drives alloc_* / res_*, observes the rest.
//   slave  modport - the queue itself.
interface branch_resolve_queue_if;
  import isa_pkg::*;

  // fetch -> queue
  logic         alloc_valid;
  logic         alloc_ready;
  logic [31:0]  alloc_pc;
  decode_ctrl_t alloc_ctrl;
  logic         alloc_pred_taken;
  logic [31:0]  alloc_pred_target;

  // EX -> queue
  logic         res_valid;
  logic         res_ready;
  logic         res_taken;
  logic [31:0]  res_target;

  // queue -> fetch redirect
  logic         redirect_valid;
  logic [31:0]  redirect_pc;

  // queue -> BHT update
  logic         upd_valid;
  decode_ctrl_t upd_ctrl;
  logic [31:0]  upd_pc;
  logic         upd_taken;

  modport master (
    output alloc_valid, alloc_pc, alloc_ctrl, alloc_pred_taken, alloc_pred_target,
    output res_valid, res_taken, res_target,
    input  alloc_ready, res_ready,
    input  redirect_valid, redirect_pc,
    input  upd_valid, upd_ctrl, upd_pc, upd_taken
  );

  modport slave (
    input  alloc_valid, alloc_pc, alloc_ctrl, alloc_pred_taken, alloc_pred_target,
    input  res_valid, res_taken, res_target,
    output alloc_ready, res_ready,
    output redirect_valid, redirect_pc,
    output upd_valid, upd_ctrl, upd_pc, upd_taken
  );

endinterface

// File: rtl/branch_resolve_queue.sv
// branch_resolve_queue: in-order tracker of predicted control-flow
// instructions. Fetch allocates one entry per predicted branch; EX resolves
// the oldest entry. Every resolution produces a registered BHT update; a
// wrong prediction additionally produces a registered redirect and empties
// the queue (all younger entries are on the wrong path).
//
// Ports:
//   clk, rst_n  - clock, synchronous active-low reset
//   flush       - external pipeline flush, empties the queue
//   brq         - branch_resolve_queue_if.slave (alloc / res / redirect / upd)
//   count       - occupancy, decoded from registered pointers
//   perf_branches, perf_mispredicts - only when BRQ_PERF_CNT_EN is defined
//
// Optional feature macro: BRQ_PERF_CNT_EN (performance counters).
module branch_resolve_queue
  import isa_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  branch_resolve_queue_if.slave  brq,
  output logic [$clog2(DEPTH):0] count
`ifdef BRQ_PERF_CNT_EN
  ,
  output logic [31:0]            perf_branches,
  output logic [31:0]            perf_mispredicts
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] DEPTH_C = PW'(DEPTH);

  // A wrong prediction is a direction mismatch, or a taken branch whose
  // predicted target differs from the real one.
  function automatic logic is_mispredict(
    input logic        pred_taken,
    input logic [31:0] pred_target,
    input logic        act_taken,
    input logic [31:0] act_target
  );
    return (pred_taken != act_taken) || (act_taken && (pred_target != act_target));
  endfunction

  // Architecturally correct next PC after the branch; wraps modulo 2^32.
  function automatic logic [31:0] correct_pc(
    input logic        act_taken,
    input logic [31:0] act_target,
    input logic [31:0] pc
  );
    return act_taken ? act_target : (pc + 32'd4);
  endfunction

  // Entry storage (no reset: contents only matter between valid pointers)
  logic [31:0]      pc_mem   [DEPTH];
  decode_ctrl_t     ctrl_mem [DEPTH];
  logic [31:0]      tgt_mem  [DEPTH];
  logic [DEPTH-1:0] pt_mem;

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [AW-1:0] wr_idx, rd_idx;

  logic          push, pop;
  logic          mispred;
  logic          clear_q;
  logic [31:0]   head_pc;
  decode_ctrl_t  head_ctrl;
  logic          head_pt;
  logic [31:0]   head_tgt;

  // Registered outputs
  logic          redirect_vld_p1;
  logic [31:0]   redirect_pc_p1;
  logic          upd_vld_p1;
  logic [31:0]   upd_pc_p1;
  decode_ctrl_t  upd_ctrl_p1;
  logic          upd_taken_p1;

  assign wr_idx = wr_ptr[AW-1:0];
  assign rd_idx = rd_ptr[AW-1:0];

  // Occupancy and ready flags depend on the registered pointers only.
  assign count           = wr_ptr - rd_ptr;
  assign brq.alloc_ready = (count != DEPTH_C);
  assign brq.res_ready   = (count != '0);

  assign push = brq.alloc_valid && brq.alloc_ready;
  assign pop  = brq.res_valid   && brq.res_ready;

  assign head_pc   = pc_mem[rd_idx];
  assign head_ctrl = ctrl_mem[rd_idx];
  assign head_pt   = pt_mem[rd_idx];
  assign head_tgt  = tgt_mem[rd_idx];

  assign mispred = pop && is_mispredict(head_pt, head_tgt, brq.res_taken, brq.res_target);

  // Either event discards every in-flight entry, including a same-cycle push.
  assign clear_q = mispred || flush;

  // ---- stage p0: entry write ----
  always_ff @(posedge clk) begin
    if (push && !clear_q) begin
      pc_mem[wr_idx]   <= brq.alloc_pc;
      ctrl_mem[wr_idx] <= brq.alloc_ctrl;
      pt_mem[wr_idx]   <= brq.alloc_pred_taken;
      tgt_mem[wr_idx]  <= brq.alloc_pred_target;
    end
  end

  // ---- stage p0: pointers ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear_q) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // ---- stage p1: registered update / redirect ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      upd_vld_p1      <= 1'b0;
      upd_pc_p1       <= '0;
      upd_ctrl_p1     <= '0;
      upd_taken_p1    <= 1'b0;
      redirect_vld_p1 <= 1'b0;
      redirect_pc_p1  <= '0;
    end else begin
      // flush does not mask the update of a branch resolving this cycle
      upd_vld_p1      <= pop;
      redirect_vld_p1 <= mispred;
      if (pop) begin
        upd_pc_p1    <= head_pc;
        upd_ctrl_p1  <= head_ctrl;
        upd_taken_p1 <= brq.res_taken;
      end
      if (mispred) begin
        redirect_pc_p1 <= correct_pc(brq.res_taken, brq.res_target, head_pc);
      end
    end
  end

  assign brq.upd_valid      = upd_vld_p1;
  assign brq.upd_pc         = upd_pc_p1;
  assign brq.upd_ctrl       = upd_ctrl_p1;
  assign brq.upd_taken      = upd_taken_p1;
  assign brq.redirect_valid = redirect_vld_p1;
  assign brq.redirect_pc    = redirect_pc_p1;

`ifdef BRQ_PERF_CNT_EN
  // ---- stage p1: performance counters (free-running, wrap at 2^32) ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_branches    <= '0;
      perf_mispredicts <= '0;
    end else begin
      if (pop)     perf_branches    <= perf_branches + 32'd1;
      if (mispred) perf_mispredicts <= perf_mispredicts + 32'd1;
    end
  end
`endif

endmodule
